// File: rtl/fifo_pkg.sv
// Shared types and helpers for the sync_fifo block.
// Read-port style is chosen in sync_fifo via SYNC_FIFO_FWFT_EN.
package fifo_pkg;

  typedef enum logic [0:0] {
    ERR_OVF = 1'b0,
    ERR_UDF = 1'b1
  } err_e;

  localparam int ERR_N = 2;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Flop-array dual-port memory: one sync write port, one read port
// that is either registered (REG_RD=1) or combinational (REG_RD=0).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter bit REG_RD = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = fifo_depth(AW);

  logic [DW-1:0] mem [DEPTH];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    if (REG_RD) begin : g_reg_rd
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata <= '0;
        end else if (clr) begin
          rdata <= '0;
        end else if (re) begin
          rdata <= mem[raddr];
        end
      end
    end else begin : g_comb_rd
      assign rdata = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level, almost flags, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic                  W_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  R_INC,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef logic [ADDR_WIDTH:0] lvl_t;

  localparam lvl_t LVL_MAX = lvl_t'(DEPTH);
  localparam lvl_t LVL_AF  = lvl_t'(AF_THRESH);
  localparam lvl_t LVL_AE  = lvl_t'(AE_THRESH);

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit REG_RD = 1'b0;
`else
  localparam bit REG_RD = 1'b1;
`endif

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  lvl_t             level_q;
  lvl_t             level_d;
  logic [ERR_N-1:0] err_q;
  logic [ERR_N-1:0] err_d;
  logic             wr_ok;
  logic             rd_ok;

  // Accepts look only at registered FULL/EMPTY; a flush masks both.
  always_comb begin
    wr_ok   = W_INC && !FULL && !CLR;
    rd_ok   = R_INC && !EMPTY && !CLR;
    level_d = level_q;
    err_d   = err_q;
    if (W_INC && FULL) begin
      err_d[ERR_OVF] = 1'b1;
    end
    if (R_INC && EMPTY) begin
      err_d[ERR_UDF] = 1'b1;
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + lvl_t'(1);
      2'b01:   level_d = level_q - lvl_t'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      err_q        <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
    end else if (CLR) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      err_q        <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      level_q      <= level_d;
      err_q        <= err_d;
      FULL         <= (level_d == LVL_MAX);
      EMPTY        <= (level_d == '0);
      ALMOST_FULL  <= (level_d >= LVL_AF);
      ALMOST_EMPTY <= (level_d <= LVL_AE);
    end
  end

  assign LEVEL     = level_q;
  assign OVERFLOW  = err_q[ERR_OVF];
  assign UNDERFLOW = err_q[ERR_UDF];

  fifo_mem #(
    .DW     (DATA_WIDTH),
    .AW     (ADDR_WIDTH),
    .REG_RD (REG_RD)
  ) u_mem (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (CLR),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (WR_DATA),
    .re    (rd_ok),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (RD_DATA)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DEPTH 8) against a queue model.
// Honours SYNC_FIFO_FWFT_EN for the read-data expectation.
module tb_sync_fifo;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CLR = 1'b0;
  logic       W_INC = 1'b0;
  logic [7:0] WR_DATA = '0;
  logic       R_INC = 1'b0;
  logic [7:0] RD_DATA;
  logic       FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
  logic [3:0] LEVEL;
  logic       OVERFLOW, UNDERFLOW;

  int cmp = 0;
  int bad = 0;

  sync_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3),
    .AF_THRESH  (6),
    .AE_THRESH  (1)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CLR          (CLR),
    .W_INC        (W_INC),
    .WR_DATA      (WR_DATA),
    .R_INC        (R_INC),
    .RD_DATA      (RD_DATA),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .LEVEL        (LEVEL),
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  // Reference model: a plain queue plus sticky bits and last-read word.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [7:0] m_rd  = '0;

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rd  = '0;
  endtask

  task automatic model_edge(input logic w, input logic [7:0] wd,
                            input logic r, input logic c);
    bit full, empty;
    if (c) begin
      model_reset();
      return;
    end
    full  = (q.size() == 8);
    empty = (q.size() == 0);
    if (r && !empty) m_rd = q.pop_front();
    if (w && !full) q.push_back(wd);
    if (w && full) m_ovf = 1'b1;
    if (r && empty) m_udf = 1'b1;
  endtask

  function automatic logic [9:0] exp_stat();
    int n = q.size();
    return {n == 8, n == 0, n >= 6, n <= 1, m_ovf, m_udf, 4'(n)};
  endfunction

  function automatic logic [9:0] dut_stat();
    return {FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
            OVERFLOW, UNDERFLOW, LEVEL};
  endfunction

  // Returns 0 when the read word is don't-care.
  function automatic bit exp_rd(output logic [7:0] e);
`ifdef SYNC_FIFO_FWFT_EN
    e = '0;
    if (q.size() == 0) return 1'b0;
    e = q[0];
    return 1'b1;
`else
    e = m_rd;
    return 1'b1;
`endif
  endfunction

  task automatic step(input logic w, input logic [7:0] wd,
                      input logic r, input logic c);
    W_INC = w; WR_DATA = wd; R_INC = r; CLR = c;
    @(posedge CLK);
    model_edge(w, wd, r, c);
    #1;
    W_INC = 1'b0; R_INC = 1'b0; CLR = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    cmp++;
    if (dut_stat() !== exp_stat()) begin
      bad++;
      $display("FAIL reset_stat: got %b want %b", dut_stat(), exp_stat());
    end
    RST = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    // Asynchronous assertion mid-cycle, no edge in between.
    RST = 1'b0;
    #1;
    model_reset();
    cmp++;
    if (dut_stat() !== exp_stat()) begin
      bad++;
      $display("FAIL async_rst_stat: got %b want %b", dut_stat(), exp_stat());
    end
    cmp++;
    if (exp_rd(e) && RD_DATA !== e) begin
      bad++;
      $display("FAIL async_rst_rd: got %h want %h", RD_DATA, e);
    end
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    cmp++;
    if (LEVEL !== 4'd0 || EMPTY !== 1'b1) begin
      bad++;
      $display("FAIL rst_release: got lvl %0d empty %b want 0 1", LEVEL, EMPTY);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, (i == 8) ? 8'hFF : 8'(8'h10 + i), 1'b0, 1'b0);
      cmp++;
      if (dut_stat() !== exp_stat()) begin
        bad++;
        $display("FAIL fill_stat[%0d]: got %b want %b", i, dut_stat(), exp_stat());
      end
    end
    cmp++;
    if (OVERFLOW !== 1'b1 || LEVEL !== 4'd8) begin
      bad++;
      $display("FAIL fill_ovf: got ovf %b lvl %0d want 1 8", OVERFLOW, LEVEL);
    end
  endtask

  task automatic test_drain();
    logic [7:0] e;
    for (int i = 0; i < 9; i++) begin
      cmp++;
      if (exp_rd(e) && RD_DATA !== e) begin
        bad++;
        $display("FAIL drain_pre[%0d]: got %h want %h", i, RD_DATA, e);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      cmp++;
      if (dut_stat() !== exp_stat()) begin
        bad++;
        $display("FAIL drain_stat[%0d]: got %b want %b", i, dut_stat(), exp_stat());
      end
      cmp++;
      if (exp_rd(e) && RD_DATA !== e) begin
        bad++;
        $display("FAIL drain_rd[%0d]: got %h want %h", i, RD_DATA, e);
      end
    end
    cmp++;
    if (UNDERFLOW !== 1'b1) begin
      bad++;
      $display("FAIL drain_udf: got %b want 1", UNDERFLOW);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    cmp++;
    if (dut_stat() !== exp_stat() || FULL !== 1'b1) begin
      bad++;
      $display("FAIL wrap_full: got %b want %b", dut_stat(), exp_stat());
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      cmp++;
      if ((exp_rd(e) && RD_DATA !== e) || dut_stat() !== exp_stat()) begin
        bad++;
        $display("FAIL wrap_rd[%0d]: got %h/%b want %h/%b",
                 i, RD_DATA, dut_stat(), e, exp_stat());
      end
    end
  endtask

  task automatic test_simul();
    logic [7:0] e;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0);
      cmp++;
      if ((exp_rd(e) && RD_DATA !== e) || LEVEL !== 4'd4) begin
        bad++;
        $display("FAIL simul_rw[%0d]: got %h lvl %0d want %h 4",
                 i, RD_DATA, LEVEL, e);
      end
    end
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    cmp++;
    if (dut_stat() !== exp_stat() || LEVEL !== 4'd7 || OVERFLOW !== 1'b1) begin
      bad++;
      $display("FAIL simul_full: got %b want %b", dut_stat(), exp_stat());
    end
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      cmp++;
      if (exp_rd(e) && RD_DATA !== e) begin
        bad++;
        $display("FAIL simul_order[%0d]: got %h want %h", i, RD_DATA, e);
      end
    end
  endtask

  task automatic test_flush();
    logic [7:0] e;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h7F, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1);
    cmp++;
    if (dut_stat() !== exp_stat() || LEVEL !== 4'd0) begin
      bad++;
      $display("FAIL flush_stat: got %b want %b", dut_stat(), exp_stat());
    end
    cmp++;
    if (exp_rd(e) && RD_DATA !== e) begin
      bad++;
      $display("FAIL flush_rd: got %h want %h", RD_DATA, e);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    cmp++;
    if (dut_stat() !== exp_stat() || UNDERFLOW !== 1'b1) begin
      bad++;
      $display("FAIL flush_discard: got %b want %b", dut_stat(), exp_stat());
    end
  endtask

  task automatic test_random();
    logic       w, r, c;
    logic [7:0] d, e;
    for (int i = 0; i < 600; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 63) == 0);
      d = 8'($urandom);
      step(w, d, r, c);
      cmp++;
      if (dut_stat() !== exp_stat()) begin
        bad++;
        $display("FAIL rand_stat[%0d]: got %b want %b", i, dut_stat(), exp_stat());
      end
      cmp++;
      if (exp_rd(e) && RD_DATA !== e) begin
        bad++;
        $display("FAIL rand_rd[%0d]: got %h want %h", i, RD_DATA, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

endmodule
